// File: rtl/tape_ctrl_pkg.sv
// Shared types for the tape controller: symbols, FSM states, fault codes, rule layout.
// The PAUSE state exists only when TAPE_CTRL_SINGLE_STEP_EN is defined.
package tape_ctrl_pkg;

    localparam logic [1:0] SYM_ZERO  = 2'b00;
    localparam logic [1:0] SYM_ONE   = 2'b01;
    localparam logic [1:0] SYM_BLANK = 2'b10;

    localparam int unsigned RULE_W    = 6;
    localparam int unsigned NUM_RULES = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_EVAL,
        S_WR,
        S_HALT
`ifdef TAPE_CTRL_SINGLE_STEP_EN
        , S_PAUSE
`endif
    } ctrl_state_e;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'b00,
        FAULT_EDGE    = 2'b01,
        FAULT_TIMEOUT = 2'b10
    } fault_e;

    // Field order matches the packed 6-bit rule word {halt, next_state, write_sym, move_right}.
    typedef struct packed {
        logic       halt;
        logic [1:0] next_state;
        logic [1:0] write_sym;
        logic       move_right;
    } rule_t;

endpackage

// File: rtl/tape_rule_lookup.sv
// Combinational rule selector: picks rule[state*3 + sym_idx] from the flat rule table.
module tape_rule_lookup
    import tape_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W = 2
) (
    input  logic [STATE_W-1:0]            state,
    input  logic [1:0]                    sym,
    input  logic [NUM_RULES*RULE_W-1:0]   rule_table,
    output rule_t                         rule
);

    rule_t      rules [NUM_RULES];
    logic [1:0] sym_idx;
    logic [3:0] idx;

    always_comb begin
        for (int unsigned i = 0; i < NUM_RULES; i++) begin
            rules[i] = rule_t'(rule_table[i*RULE_W +: RULE_W]);
        end
        // Any symbol with the high bit set reads as blank.
        sym_idx = sym[1] ? 2'd2 : {1'b0, sym[0]};
        idx     = 4'(state) * 4'd3 + 4'(sym_idx);
        rule    = rules[idx];
    end

endmodule

// File: rtl/tape_controller.sv
// Turing-machine sequencer driving an 8-cell tape: RD -> EVAL -> WR per step.
// Optional single-step mode (PAUSE state, step_req port) under TAPE_CTRL_SINGLE_STEP_EN.
module tape_controller
    import tape_ctrl_pkg::*;
#(
    parameter int unsigned HEAD_W    = 3,
    parameter int unsigned STATE_W   = 2,
    parameter int unsigned STEP_W    = 16,
    parameter int unsigned MAX_STEPS = 1000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
`ifdef TAPE_CTRL_SINGLE_STEP_EN
    input  logic                        step_req,
`endif
    input  logic [HEAD_W-1:0]           head_init,
    input  logic [NUM_RULES*RULE_W-1:0] rule_table,
    output logic                        tape_mode,
    output logic [HEAD_W-1:0]           tape_head,
    output logic [1:0]                  tape_in,
    input  logic [1:0]                  tape_out,
    output logic                        busy,
    output logic                        done,
    output logic [1:0]                  fault,
    output logic [STATE_W-1:0]          tm_state,
    output logic [STEP_W-1:0]           steps
);

    ctrl_state_e state;
    rule_t       rule_d;
    rule_t       rule_q;
    logic        at_edge;
    logic        last_step;

    tape_rule_lookup #(.STATE_W(STATE_W)) u_lookup (
        .state      (tm_state),
        .sym        (tape_out),
        .rule_table (rule_table),
        .rule       (rule_d)
    );

    assign at_edge   = rule_q.move_right ? (tape_head == '1) : (tape_head == '0);
    assign last_step = (steps == STEP_W'(MAX_STEPS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            rule_q    <= '0;
            tape_mode <= 1'b0;
            tape_head <= '0;
            tape_in   <= SYM_BLANK;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= FAULT_NONE;
            tm_state  <= '0;
            steps     <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        tape_head <= head_init;
                        tm_state  <= '0;
                        steps     <= '0;
                        done      <= 1'b0;
                        fault     <= FAULT_NONE;
                        busy      <= 1'b1;
                        state     <= S_RD;
                    end
                end
                S_RD: state <= S_EVAL;
                S_EVAL: begin
                    rule_q    <= rule_d;
                    tape_in   <= rule_d.write_sym;
                    tape_mode <= 1'b1;
                    state     <= S_WR;
                end
                S_WR: begin
                    tape_mode <= 1'b0;
                    steps     <= steps + 1'b1;
                    tm_state  <= STATE_W'(rule_q.next_state);
                    // Priority: halt, then edge fault, then timeout (which still moves the head).
                    if (rule_q.halt) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_HALT;
                    end else if (at_edge) begin
                        fault <= FAULT_EDGE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_HALT;
                    end else begin
                        tape_head <= rule_q.move_right ? tape_head + 1'b1 : tape_head - 1'b1;
                        if (last_step) begin
                            fault <= FAULT_TIMEOUT;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_HALT;
                        end else begin
`ifdef TAPE_CTRL_SINGLE_STEP_EN
                            state <= S_PAUSE;
`else
                            state <= S_RD;
`endif
                        end
                    end
                end
`ifdef TAPE_CTRL_SINGLE_STEP_EN
                S_PAUSE: begin
                    if (step_req) begin
                        state <= S_RD;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tape_controller.sv
// Self-checking bench for tape_controller with a behavioural 8-cell tape model.
// Single-step sequence is exercised only when TAPE_CTRL_SINGLE_STEP_EN is defined.
module tb_tape_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  head_init;
    logic [71:0] rule_table;
    logic        tape_mode;
    logic [2:0]  tape_head;
    logic [1:0]  tape_in;
    logic [1:0]  tape_out;
    logic        busy;
    logic        done;
    logic [1:0]  fault;
    logic [1:0]  tm_state;
    logic [15:0] steps;
`ifdef TAPE_CTRL_SINGLE_STEP_EN
    logic        step_req;
`endif

    // Behavioural tape: registered read, write when tape_mode=1, bench-side bulk load.
    logic [7:0][1:0] cells;
    logic [7:0][1:0] load_img;
    logic            load_req;
    int              wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tape_controller #(.MAX_STEPS(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
`ifdef TAPE_CTRL_SINGLE_STEP_EN
        .step_req   (step_req),
`endif
        .head_init  (head_init),
        .rule_table (rule_table),
        .tape_mode  (tape_mode),
        .tape_head  (tape_head),
        .tape_in    (tape_in),
        .tape_out   (tape_out),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .tm_state   (tm_state),
        .steps      (steps)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tape_out <= 2'b00;
        end else if (load_req) begin
            cells    <= load_img;
            wr_count <= 0;
        end else if (tape_mode) begin
            cells[tape_head] <= tape_in;
            wr_count         <= wr_count + 1;
        end else begin
            tape_out <= cells[tape_head];
        end
    end

    typedef struct {
        string       name;
        logic [2:0]  head;
        logic [71:0] rules;
        logic [15:0] img;
        int          exp_steps;
        int          exp_head;
        int          exp_fault;
        int          exp_state;
        int          exp_cycles;
        logic [15:0] exp_img;
        int          exp_writes;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [5:0] mk_rule(input logic h, input logic [1:0] ns,
                                           input logic [1:0] ws, input logic mr);
        return {h, ns, ws, mr};
    endfunction

    function automatic logic [71:0] rt_default();
        logic [71:0] rt;
        for (int i = 0; i < 12; i++) rt[i*6 +: 6] = mk_rule(1'b1, 2'd0, 2'b10, 1'b0);
        return rt;
    endfunction

    function automatic logic [15:0] img_fill(input logic [1:0] s);
        logic [15:0] v;
        for (int i = 0; i < 8; i++) v[i*2 +: 2] = s;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_tape(input logic [15:0] img);
        @(negedge clk);
        load_img = img;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic pulse_start(input logic [2:0] h);
        @(negedge clk);
        head_init = h;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Called right after pulse_start; counts busy cycles until done, bounded.
    task automatic wait_done(input string name, output int cycles);
        int guard = 0;
        cycles = 0;
        while (!done && guard < 300) begin
            if (busy) cycles++;
            @(negedge clk);
            guard++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: done never rose, got 0 expected 1", name);
        end
    endtask

    initial begin
        logic [71:0] rt;
        logic [15:0] img;
        int          cyc;
        int          guard;

        reset      = 1'b1;
        start      = 1'b0;
        head_init  = 3'd0;
        rule_table = '0;
        load_req   = 1'b0;
        load_img   = '0;
        wr_count   = 0;
`ifdef TAPE_CTRL_SINGLE_STEP_EN
        step_req   = 1'b0;
`endif

        // Unary increment: 1,1,1,blank -> halt at cell 3 after 4 steps.
        rt = rt_default();
        rt[1*6 +: 6] = mk_rule(1'b0, 2'd0, 2'b01, 1'b1);
        rt[2*6 +: 6] = mk_rule(1'b1, 2'd0, 2'b01, 1'b0);
        img = img_fill(2'b10);
        img[1:0] = 2'b01; img[3:2] = 2'b01; img[5:4] = 2'b01;
        vecs[0] = '{"unary", 3'd0, rt, img, 4, 3, 0, 0, 12, 16'b0, 4};
        vecs[0].exp_img = img;
        vecs[0].exp_img[7:6] = 2'b01;

        // Right-edge fault from head 7.
        rt = rt_default();
        for (int i = 0; i < 3; i++) rt[i*6 +: 6] = mk_rule(1'b0, 2'd0, 2'b00, 1'b1);
        img = img_fill(2'b10);
        vecs[1] = '{"edge_r", 3'd7, rt, img, 1, 7, 1, 0, 3, img, 1};
        vecs[1].exp_img[15:14] = 2'b00;

        // Ping-pong between cells 3 and 4 until the 10-step budget runs out.
        rt = rt_default();
        for (int i = 0; i < 3; i++) rt[i*6 +: 6] = mk_rule(1'b0, 2'd1, 2'b01, 1'b1);
        for (int i = 3; i < 6; i++) rt[i*6 +: 6] = mk_rule(1'b0, 2'd0, 2'b00, 1'b0);
        img = img_fill(2'b10);
        vecs[2] = '{"timeout", 3'd3, rt, img, 10, 3, 2, 0, 30, img, 10};
        vecs[2].exp_img[7:6] = 2'b01;
        vecs[2].exp_img[9:8] = 2'b00;

        // Halt at right edge beats edge fault; symbol still written.
        rt = rt_default();
        rt[2*6 +: 6] = mk_rule(1'b1, 2'd2, 2'b01, 1'b1);
        img = img_fill(2'b10);
        vecs[3] = '{"halt_edge", 3'd7, rt, img, 1, 7, 0, 2, 3, img, 1};
        vecs[3].exp_img[15:14] = 2'b01;

        // Left-edge fault after a state change.
        rt = rt_default();
        rt[2*6 +: 6] = mk_rule(1'b0, 2'd1, 2'b00, 1'b0);
        rt[5*6 +: 6] = mk_rule(1'b0, 2'd0, 2'b01, 1'b0);
        img = img_fill(2'b10);
        vecs[4] = '{"edge_l", 3'd1, rt, img, 2, 0, 1, 0, 6, img, 2};
        vecs[4].exp_img[1:0] = 2'b01;
        vecs[4].exp_img[3:2] = 2'b00;

        repeat (2) @(negedge clk);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_mode",  32'(tape_mode), 0);
        chk("rst_head",  32'(tape_head), 0);
        chk("rst_in",    32'(tape_in), 32'h2);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_state", 32'(tm_state), 0);
        chk("rst_steps", 32'(steps), 0);
        reset = 1'b0;

`ifndef TAPE_CTRL_SINGLE_STEP_EN
        for (int v = 0; v < 5; v++) begin
            rule_table = vecs[v].rules;
            load_tape(vecs[v].img);
            pulse_start(vecs[v].head);
            wait_done(vecs[v].name, cyc);
            chk({vecs[v].name, "_cycles"}, 32'(cyc), 32'(vecs[v].exp_cycles));
            chk({vecs[v].name, "_steps"},  32'(steps), 32'(vecs[v].exp_steps));
            chk({vecs[v].name, "_head"},   32'(tape_head), 32'(vecs[v].exp_head));
            chk({vecs[v].name, "_fault"},  32'(fault), 32'(vecs[v].exp_fault));
            chk({vecs[v].name, "_state"},  32'(tm_state), 32'(vecs[v].exp_state));
            repeat (4) @(negedge clk);
            chk({vecs[v].name, "_done"},   32'(done), 1);
            chk({vecs[v].name, "_busy"},   32'(busy), 0);
            chk({vecs[v].name, "_writes"}, 32'(wr_count), 32'(vecs[v].exp_writes));
            chk({vecs[v].name, "_tape"},   32'(cells), 32'(vecs[v].exp_img));
        end

        // Start while busy is ignored; start after done restarts from steps=0.
        rule_table = vecs[0].rules;
        load_tape(vecs[0].img);
        pulse_start(3'd0);
        guard = 0;
        while (steps != 16'd2 && guard < 50) begin @(negedge clk); guard++; end
        chk("busy_start_reach", 32'(steps), 2);
        pulse_start(3'd5);
        wait_done("busy_start", cyc);
        chk("busy_start_steps", 32'(steps), 4);
        chk("busy_start_head",  32'(tape_head), 3);
        chk("busy_start_fault", 32'(fault), 0);
        pulse_start(3'd0);
        chk("restart_steps0", 32'(steps), 0);
        chk("restart_busy",   32'(busy), 1);
        chk("restart_done0",  32'(done), 0);
        wait_done("restart", cyc);
        chk("restart_steps",  32'(steps), 5);
        chk("restart_head",   32'(tape_head), 4);
        chk("restart_cycles", 32'(cyc), 15);

        // Reset asserted during the first WR cycle aborts before the write commits.
        rt = rt_default();
        rt[1*6 +: 6] = mk_rule(1'b0, 2'd1, 2'b00, 1'b1);
        rule_table = rt;
        load_tape(vecs[0].img);
        pulse_start(3'd0);
        guard = 0;
        while (!tape_mode && guard < 20) begin @(negedge clk); guard++; end
        chk("abort_in_wr", 32'(tape_mode), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy",   32'(busy), 0);
        chk("abort_mode",   32'(tape_mode), 0);
        chk("abort_head",   32'(tape_head), 0);
        chk("abort_in",     32'(tape_in), 32'h2);
        chk("abort_steps",  32'(steps), 0);
        chk("abort_state",  32'(tm_state), 0);
        chk("abort_cell0",  32'(cells[0]), 1);
        chk("abort_writes", 32'(wr_count), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_idle", 32'(busy), 0);
`else
        // One step per step_req pulse; PAUSE keeps busy high with tape_mode low.
        rule_table = vecs[0].rules;
        load_tape(vecs[0].img);
        pulse_start(3'd0);
        repeat (8) @(negedge clk);
        chk("ss_steps1", 32'(steps), 1);
        chk("ss_busy",   32'(busy), 1);
        chk("ss_mode",   32'(tape_mode), 0);
        chk("ss_head",   32'(tape_head), 1);
        for (int k = 2; k <= 3; k++) begin
            step_req = 1'b1;
            @(negedge clk);
            step_req = 1'b0;
            repeat (6) @(negedge clk);
            chk("ss_step_count", 32'(steps), 32'(k));
            chk("ss_pause_mode", 32'(tape_mode), 0);
            chk("ss_pause_busy", 32'(busy), 1);
        end
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("ss_done",  32'(done), 1);
        chk("ss_final", 32'(steps), 4);
        chk("ss_hd",    32'(tape_head), 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
